// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker for the 5-stage pipeline: EX/MEM/WB destination slots,
// decode stall / EX bubble generation, HALT drain sequencing and a saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned NB_REG = 5,
  parameter int unsigned NB_CNT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              id_valid,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [NB_REG-1:0] id_write_reg,
  input  logic              id_halt,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              pipe_empty,
  output logic              halted,
  output logic [NB_CNT-1:0] stall_count
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [NB_REG-1:0] rd;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  slot_t             r_ex;
  slot_t             r_mem;
  // No decision depends on the WB record's fields, so only its occupancy is kept.
  logic              r_wb_valid;
  logic [NB_CNT-1:0] r_stall_count;

  slot_t             w_ex_next;
  logic              w_ex_rs;
  logic              w_ex_rt;
  logic              w_mem_rs;
  logic              w_mem_rt;
  logic              w_load_use;
  logic              w_branch_haz;
  logic              w_stall;
  logic              w_issue;

  function automatic logic f_match(input slot_t s, input logic [NB_REG-1:0] src,
                                   input logic use_src);
    return s.valid & s.reg_write & (s.rd == src) & (src != '0) & use_src;
  endfunction

  // Hazard detection against the EX and MEM producers
  always_comb begin
    w_ex_rs      = f_match(r_ex,  id_rs, id_use_rs);
    w_ex_rt      = f_match(r_ex,  id_rt, id_use_rt);
    w_mem_rs     = f_match(r_mem, id_rs, id_use_rs);
    w_mem_rt     = f_match(r_mem, id_rt, id_use_rt);
    w_load_use   = r_ex.mem_read & (w_ex_rs | w_ex_rt);
    w_branch_haz = id_is_branch &
                   ((w_ex_rs | w_ex_rt) | (r_mem.mem_read & (w_mem_rs | w_mem_rt)));
    w_stall      = id_valid & (w_load_use | w_branch_haz) & (r_state == ST_RUN);
    w_issue      = id_valid & ~w_stall & (r_state == ST_RUN);
  end

  // Record entering EX; HALT travels as a non-writing entry
  always_comb begin
    w_ex_next = '0;
    if (w_issue) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.reg_write = id_reg_write & ~id_halt;
      w_ex_next.mem_read  = id_mem_read & ~id_halt;
      w_ex_next.rd        = id_halt ? '0 : id_write_reg;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:    if (w_issue && id_halt) w_next_state = ST_DRAIN;
      // Nothing issues in DRAIN, so all slots empty after this edge iff EX and MEM are empty now
      ST_DRAIN:  if (!r_ex.valid && !r_mem.valid) w_next_state = ST_HALTED;
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else if (enable) begin
      r_state <= w_next_state;
    end
  end

  // Slot pipeline and stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb_valid    <= 1'b0;
      r_stall_count <= '0;
    end else if (enable) begin
      r_ex       <= w_ex_next;
      r_mem      <= r_ex;
      r_wb_valid <= r_mem.valid;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + NB_CNT'(1);
      end
    end
  end

  assign stall_id    = w_stall;
  assign bubble_ex   = w_stall;
  assign pipe_empty  = ~(r_ex.valid | r_mem.valid | r_wb_valid);
  assign halted      = (r_state == ST_HALTED);
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_branch;
  logic        id_reg_write;
  logic        id_mem_read;
  logic [4:0]  id_write_reg;
  logic        id_halt;
  logic        stall_id;
  logic        bubble_ex;
  logic        pipe_empty;
  logic        halted;
  logic [31:0] stall_count;

  typedef struct {
    string       name;
    logic        stall;
    logic        empty;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  hazard_scoreboard #(.NB_REG(5), .NB_CNT(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_write_reg (id_write_reg),
    .id_halt      (id_halt),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .pipe_empty   (pipe_empty),
    .halted       (halted),
    .stall_count  (stall_count)
  );

  task automatic check1(input string nm, input string fld, input logic [31:0] act,
                        input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1(e.name, "stall_id",    32'(stall_id),   32'(e.stall));
      check1(e.name, "bubble_ex",   32'(bubble_ex),  32'(e.stall));
      check1(e.name, "pipe_empty",  32'(pipe_empty), 32'(e.empty));
      check1(e.name, "halted",      32'(halted),     32'(e.halt));
      check1(e.name, "stall_count", stall_count,     e.cnt);
    end
  end

  // One cycle: drive inputs just after the edge, queue the outputs expected this cycle
  task automatic step(input string nm, input logic rst, input logic en, input logic v,
                      input logic hlt, input logic br, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt, input logic rw, input logic mr,
                      input logic [4:0] wr, input logic e_st, input logic e_em,
                      input logic e_ha, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; enable = en; id_valid = v; id_halt = hlt; id_is_branch = br;
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_write_reg = wr;
    e.name = nm; e.stall = e_st; e.empty = e_em; e.halt = e_ha; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic e_st, input logic e_em,
                     input logic e_ha, input logic [31:0] e_cnt);
    step(nm, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_st, e_em, e_ha, e_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; id_valid = 1'b0; id_halt = 1'b0; id_is_branch = 1'b0;
    id_rs = '0; id_use_rs = 1'b0; id_rt = '0; id_use_rt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_write_reg = '0;
    @(posedge clock);
    //   name           rst en v  hlt br rs urs rt urt rw mr wr   st em ha cnt
    step("reset",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    // Load-use: LW r5 then ADD r6,r5,r1
    step("t1_lw",        0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0);
    step("t1_use",       0, 1, 1, 0, 0, 5, 1, 1, 1, 1, 0, 6,   1, 0, 0, 0);
    step("t1_issue",     0, 1, 1, 0, 0, 5, 1, 1, 1, 1, 0, 6,   0, 0, 0, 1);
    nop("t1_add_ex",   0, 0, 0, 1);
    nop("t1_add_mem",  0, 0, 0, 1);
    nop("t1_add_wb",   0, 0, 0, 1);
    // ALU result feeding a branch: one stall, then MEM forwarding
    step("t2_add",       0, 1, 1, 0, 0, 1, 1, 2, 1, 1, 0, 3,   0, 1, 0, 1);
    step("t2_beq_ex",    0, 1, 1, 0, 1, 3, 1, 4, 1, 0, 0, 0,   1, 0, 0, 1);
    step("t2_beq_mem",   0, 1, 1, 0, 1, 3, 1, 4, 1, 0, 0, 0,   0, 0, 0, 2);
    nop("t2_d1",       0, 0, 0, 2);
    nop("t2_d2",       0, 0, 0, 2);
    nop("t2_d3",       0, 0, 0, 2);
    // Load feeding a branch: two stalls
    step("t3_lw",        0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 7,   0, 1, 0, 2);
    step("t3_beq_ex",    0, 1, 1, 0, 1, 7, 1, 0, 1, 0, 0, 0,   1, 0, 0, 2);
    step("t3_beq_mem",   0, 1, 1, 0, 1, 7, 1, 0, 1, 0, 0, 0,   1, 0, 0, 3);
    step("t3_beq_go",    0, 1, 1, 0, 1, 7, 1, 0, 1, 0, 0, 0,   0, 0, 0, 4);
    nop("t3_d1",       0, 0, 0, 4);
    nop("t3_d2",       0, 0, 0, 4);
    nop("t3_d3",       0, 0, 0, 4);
    // r0 exemption and unused-source gating
    step("t4_lw_r0",     0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0,   0, 1, 0, 4);
    step("t4_add_r0",    0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1,   0, 0, 0, 4);
    step("t4_no_use_rt", 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 4);
    nop("t4_d1",       0, 0, 0, 4);
    nop("t4_d2",       0, 0, 0, 4);
    nop("t4_d3",       0, 0, 0, 4);
    // HALT with three instructions in flight, junk issue attempts during drain
    step("t5_i1",        0, 1, 1, 0, 0, 1, 1, 2, 1, 1, 0, 10,  0, 1, 0, 4);
    step("t5_i2",        0, 1, 1, 0, 0, 1, 1, 2, 1, 1, 0, 11,  0, 0, 0, 4);
    step("t5_i3",        0, 1, 1, 0, 0, 1, 1, 2, 1, 1, 0, 12,  0, 0, 0, 4);
    step("t5_halt",      0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 4);
    step("t5_drain_ex",  0, 1, 1, 0, 1, 12, 1, 0, 0, 1, 0, 13, 0, 0, 0, 4);
    step("t5_drain_mem", 0, 1, 1, 0, 1, 12, 1, 0, 0, 1, 0, 13, 0, 0, 0, 4);
    step("t5_drain_wb",  0, 1, 1, 0, 1, 12, 1, 0, 0, 1, 0, 13, 0, 0, 0, 4);
    step("t5_halted",    0, 1, 1, 0, 1, 12, 1, 0, 0, 1, 0, 13, 0, 1, 1, 4);
    step("t5_halted2",   0, 1, 1, 0, 1, 12, 1, 0, 0, 1, 0, 13, 0, 1, 1, 4);
    // Reset out of HALTED, then freeze for 5 cycles mid-hazard
    step("t6_reset",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 4);
    step("t6_lw",        0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("t6_frz%0d", i),
                         0, 0, 1, 0, 0, 5, 1, 1, 1, 1, 0, 6,   1, 0, 0, 0);
    step("t6_resume",    0, 1, 1, 0, 0, 5, 1, 1, 1, 1, 0, 6,   1, 0, 0, 0);
    step("t6_issue",     0, 1, 1, 0, 0, 5, 1, 1, 1, 1, 0, 6,   0, 0, 0, 1);
    // Reset mid-DRAIN with enable low
    step("t7_halt",      0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    nop("t7_drain",    0, 0, 0, 1);
    step("t7_reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    nop("t7_post",     0, 1, 0, 0);
    // HALT held back by a load-use hazard
    step("t8_lw",        0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0);
    step("t8_halt_stall",0, 1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    step("t8_halt_go",   0, 1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    nop("t8_d1",       0, 0, 0, 1);
    nop("t8_d2",       0, 0, 0, 1);
    nop("t8_d3",       0, 0, 0, 1);
    nop("t8_halted",   0, 1, 1, 1);
    @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
